ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Upstream input stage of the two-player plane game. Receives PS/2 keyboard frames on kclk/kData and
//  decodes make/break/extended scan codes into a level vector `pressed` (one bit per game key).
//  Also produces one-cycle press pulses `press_evt`, so fire keys yield exactly one bullet per keystroke.
//  Feeds the key-to-action mapper (Amove/Afire/Bmove/Bfire) and the game kernel; runs on the 50 MHz system clock.
// PARAMETERS
//  FILT     4        cycles kclk must hold a new level before it is accepted (glitch filter)
//  TIMEOUT  100000   cycles (2 ms) without a kclk falling edge mid-frame before the frame is aborted
// PORTS
//  clk        in   1  system clock, 50 MHz
//  rst        in   1  asynchronous, active-high reset
//  kclk       in   1  PS/2 clock from keyboard, asynchronous
//  kData      in   1  PS/2 data from keyboard, asynchronous
//  pressed    out  8  level: key i currently held
//  press_evt  out  8  1-cycle pulse: key i went from released to pressed
//  rx_byte    out  8  last correctly received byte (debug/LED)
//  rx_valid   out  1  1-cycle pulse when rx_byte updates
//  frame_err  out  1  1-cycle pulse on parity, stop-bit or timeout error
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; ext/brk flags 0; filtered kclk = 1.
//  Input: kclk and kData each pass through a 2-FF synchroniser. kclk then passes the FILT filter.
//   A falling edge of filtered kclk is a sample strobe; kData is sampled on that strobe.
//  Frame FSM (strobe-driven): IDLE -> DATA on a start bit of 0 (a start bit of 1 is ignored, stay IDLE).
//   DATA: 8 bits LSB first, bit counter 0..7 -> PARITY. PARITY: parity bit is stored -> STOP.
//   STOP: stop bit must be 1 and parity odd over data+parity. If so, rx_byte is loaded and rx_valid pulses
//   in the cycle after the stop strobe. Otherwise frame_err pulses, the byte is dropped and ext/brk are cleared.
//   The FSM returns to IDLE in both cases.
//  Timeout: a watchdog counts cycles while not in IDLE and clears on each strobe. At TIMEOUT: frame_err pulses,
//   the FSM returns to IDLE, ext/brk are cleared. Partial bits are discarded.
//  Decode (on rx_valid): 0xE0 sets ext. 0xF0 sets brk. Any other byte is matched against the key table
//   using the current ext, then ext and brk are cleared.
//   Key table (ext,code -> bit): 0,1D->0 W | 0,1B->1 S | 0,29->2 Space | 1,75->3 Up | 1,72->4 Down |
//   0,5A->5 Enter | 0,76->6 Esc | 0,4D->7 P. A non-matching code (including a wrong ext) has no effect.
//  Make (brk=0): pressed[i] is set. press_evt[i] pulses for exactly 1 cycle only if pressed[i] was 0.
//   Typematic repeats therefore produce no further events.
//  Break (brk=1): pressed[i] is cleared; no event.
//  Latency: the stop-bit strobe is followed by pressed/press_evt updating 2 cycles later (decode is registered).
//  Simultaneous events: only one byte is decoded per frame, so at most one bit of press_evt is high in any cycle.
//   A timeout and a strobe in the same cycle: the strobe wins and the watchdog clears.
//  rst asserted mid-frame aborts at once to the reset state. No frame_err is produced for that abort.
//  Key state is held indefinitely with no auto-release; a lost break code is recovered by the next break.
// STRUCTURE
//  Shared package ps2_pkg holds:
//   - the scan-code constants (SC_EXT=8'hE0, SC_BRK=8'hF0 and the 8 key codes)
//   - the key index localparams (KEY_W..KEY_P)
//   - FILT and TIMEOUT defaults.
//  One sub-module, ps2_frame_rx, contains the synchroniser, filter, frame FSM and watchdog.
//   Its outputs are rx_byte, rx_valid and frame_err.
//  The top level holds only the ext/brk prefix register, the table match and the pressed/press_evt registers.
// TESTING
//  1 Frame 0x1D (bits 1,0,1,1,1,0,0,0, parity 1, stop 1) at a 12.5 kHz kclk:
//    rx_byte=1D, pressed=8'h01, press_evt=8'h01 for one cycle.
//  2 Send 1D three times, then F0,1D: exactly one press_evt[0] pulse; pressed[0] goes 1 and then 0 after 1D.
//  3 E0,75 then 75 without prefix: E0,75 sets pressed[3]; the bare 75 leaves pressed unchanged.
//    E0,F0,75 clears pressed[3].
//  4 Frame 0x29 with the parity bit flipped: frame_err pulses once, pressed stays 00, and the next good frame decodes.
//  5 Stop kclk after 4 data bits for more than TIMEOUT cycles: frame_err pulses, FSM is IDLE,
//    and a following 5A frame sets pressed[5].
//  6 A 2-cycle low glitch on kclk in IDLE gives no strobe. Assert rst mid-frame: all outputs 0 and no frame_err.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard input stage.
package ps2_pkg;

  localparam int unsigned FILT_DEF    = 4;
  localparam int unsigned TIMEOUT_DEF = 100000;
  localparam int unsigned NKEYS       = 8;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_P     = 8'h4D;

  localparam int unsigned KEY_W     = 0;
  localparam int unsigned KEY_S     = 1;
  localparam int unsigned KEY_SPACE = 2;
  localparam int unsigned KEY_UP    = 3;
  localparam int unsigned KEY_DOWN  = 4;
  localparam int unsigned KEY_ENTER = 5;
  localparam int unsigned KEY_ESC   = 6;
  localparam int unsigned KEY_P     = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_match_t;

  // Map an (extended, code) pair onto a game key index.
  function automatic key_match_t key_lookup(input logic ext, input logic [7:0] code);
    key_match_t m;
    m.hit = 1'b1;
    m.idx = 3'd0;
    case ({ext, code})
      {1'b0, SC_W}:     m.idx = 3'(KEY_W);
      {1'b0, SC_S}:     m.idx = 3'(KEY_S);
      {1'b0, SC_SPACE}: m.idx = 3'(KEY_SPACE);
      {1'b1, SC_UP}:    m.idx = 3'(KEY_UP);
      {1'b1, SC_DOWN}:  m.idx = 3'(KEY_DOWN);
      {1'b0, SC_ENTER}: m.idx = 3'(KEY_ENTER);
      {1'b0, SC_ESC}:   m.idx = 3'(KEY_ESC);
      {1'b0, SC_P}:     m.idx = 3'(KEY_P);
      default:          m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchroniser, kclk glitch filter, frame FSM and watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT    = FILT_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kdata,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILT + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  logic          kclk_s1, kclk_s2, kdat_s1, kdat_s2;
  logic          kclk_f;
  logic [FW-1:0] fcnt;
  logic          strobe_c;
  rx_state_t     state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [WW-1:0] wd;

  // Two-flop synchronisers; idle-high so reset creates no false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kclk_s1 <= 1'b1;
      kclk_s2 <= 1'b1;
      kdat_s1 <= 1'b1;
      kdat_s2 <= 1'b1;
    end else begin
      kclk_s1 <= kclk;
      kclk_s2 <= kclk_s1;
      kdat_s1 <= kdata;
      kdat_s2 <= kdat_s1;
    end
  end

  // Accept a new kclk level only after it has held for FILT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kclk_f <= 1'b1;
      fcnt   <= '0;
    end else if (kclk_s2 == kclk_f) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILT - 1)) begin
      kclk_f <= kclk_s2;
      fcnt   <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  // Sample strobe: filtered kclk is about to fall.
  assign strobe_c = kclk_f & ~kclk_s2 & (fcnt == FW'(FILT - 1));

  // Frame FSM with watchdog; a strobe always takes priority over a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      wd        <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (strobe_c) begin
        wd <= '0;
        case (state)
          ST_IDLE: begin
            if (!kdat_s2) begin
              state  <= ST_DATA;
              bitcnt <= '0;
            end
          end
          ST_DATA: begin
            shreg <= {kdat_s2, shreg[7:1]};
            if (bitcnt == 3'd7) state <= ST_PARITY;
            else                bitcnt <= bitcnt + 3'd1;
          end
          ST_PARITY: begin
            par   <= kdat_s2;
            state <= ST_STOP;
          end
          ST_STOP: begin
            if (kdat_s2 && (^{shreg, par})) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (wd == WW'(TIMEOUT - 1)) begin
          frame_err <= 1'b1;
          state     <= ST_IDLE;
          wd        <= '0;
        end else begin
          wd <= wd + WW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: turns received scan codes into held-key levels and press pulses.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILT    = FILT_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kclk,
  input  logic       kData,
  output logic [7:0] pressed,
  output logic [7:0] press_evt,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  logic       ext, brk;
  key_match_t match_c;

  ps2_frame_rx #(
    .FILT    (FILT),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .kclk      (kclk),
    .kdata     (kData),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  assign match_c = key_lookup(ext, rx_byte);

  // Prefix tracking and key state; a press pulse fires only on a released->held change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      pressed   <= '0;
      press_evt <= '0;
    end else begin
      press_evt <= '0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_valid) begin
        if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          if (match_c.hit) begin
            if (brk) begin
              pressed[match_c.idx] <= 1'b0;
            end else begin
              pressed[match_c.idx]   <= 1'b1;
              press_evt[match_c.idx] <= ~pressed[match_c.idx];
            end
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder with a shortened watchdog and fast kclk.
module tb_ps2_key_decoder;

  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kclk = 1'b1;
  logic       kData = 1'b1;
  logic [7:0] pressed, press_evt, rx_byte;
  logic       rx_valid, frame_err;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_rx[$];
  logic [7:0] exp_evt[$];
  logic [7:0] m_pressed = 8'h00;
  bit         m_ext = 1'b0;
  bit         m_brk = 1'b0;

  logic [7:0] key_codes [8] = '{8'h1D, 8'h1B, 8'h29, 8'h75, 8'h72, 8'h5A, 8'h76, 8'h4D};
  logic [7:0] key_ext   = 8'b0001_1000;

  ps2_key_decoder #(.FILT(4), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .kclk      (kclk),
    .kData     (kData),
    .pressed   (pressed),
    .press_evt (press_evt),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference decode of one good byte; queues the expected rx and press results.
  task automatic model_byte(input logic [7:0] b);
    exp_rx.push_back({1'b0, b});
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      for (int k = 0; k < 8; k++) begin
        if (key_codes[k] == b && key_ext[k] == m_ext) begin
          if (m_brk) m_pressed[k] = 1'b0;
          else begin
            if (!m_pressed[k]) exp_evt.push_back(8'(1 << k));
            m_pressed[k] = 1'b1;
          end
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_err();
    exp_rx.push_back(9'h100);
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic send_bit(input logic d);
    kData = d;
    wait_clk(HALF);
    kclk = 1'b0;
    wait_clk(HALF);
    kclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic p;
    p = (~^b) ^ bad;
    if (bad) model_err();
    else     model_byte(b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    kData = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic pop_rx(input logic [8:0] got, input string tag);
    if (exp_rx.size() == 0) chk({tag, "_unexpected"}, 32'(got), 32'h1FF);
    else                    chk(tag, 32'(got), 32'(exp_rx.pop_front()));
  endtask

  // Output monitor: every DUT event must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)  pop_rx({1'b0, rx_byte}, "rx_byte");
      if (frame_err) pop_rx(9'h100, "frame_err");
      if (press_evt != 8'h00) begin
        if (exp_evt.size() == 0) chk("press_evt_unexpected", 32'(press_evt), 32'h0);
        else                     chk("press_evt", 32'(press_evt), 32'(exp_evt.pop_front()));
      end
    end
  end

  initial begin
    wait_clk(3);
    chk("rst_pressed",   32'(pressed),   32'h0);
    chk("rst_press_evt", 32'(press_evt), 32'h0);
    chk("rst_rx_byte",   32'(rx_byte),   32'h0);
    chk("rst_flags",     32'({rx_valid, frame_err}), 32'h0);
    rst = 1'b0;
    wait_clk(10);

    // Single make code
    send_frame(8'h1D, 1'b0);
    wait_clk(5);
    chk("t1_rx_byte", 32'(rx_byte), 32'h1D);
    chk("t1_pressed", 32'(pressed), 32'h01);

    // Typematic repeats then break
    send_frame(8'h1D, 1'b0);
    send_frame(8'h1D, 1'b0);
    chk("t2_held", 32'(pressed), 32'h01);
    send_frame(8'hF0, 1'b0);
    chk("t2_brk_pending", 32'(pressed), 32'h01);
    send_frame(8'h1D, 1'b0);
    chk("t2_released", 32'(pressed), 32'h00);

    // Extended codes
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("t3_up", 32'(pressed), 32'h08);
    send_frame(8'h75, 1'b0);
    chk("t3_bare75", 32'(pressed), 32'h08);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    chk("t3_up_rel", 32'(pressed), 32'h00);

    // Parity error then recovery
    send_frame(8'h29, 1'b1);
    chk("t4_after_err", 32'(pressed), 32'h00);
    send_frame(8'h29, 1'b0);
    chk("t4_space", 32'(pressed), 32'h04);

    // Watchdog abort mid-frame also drops a pending E0
    send_frame(8'hE0, 1'b0);
    model_err();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    wait_clk(TO + 300);
    send_frame(8'h75, 1'b0);
    chk("t5_ext_cleared", 32'(pressed), 32'h04);
    send_frame(8'h5A, 1'b0);
    chk("t5_enter", 32'(pressed), 32'h24);

    // Short kclk glitch in idle must not start a frame
    kData = 1'b0;
    kclk  = 1'b0;
    wait_clk(2);
    kclk  = 1'b1;
    kData = 1'b1;
    wait_clk(TO + 300);
    chk("t6_glitch", 32'(pressed), 32'h24);

    // Reset mid-frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    wait_clk(2);
    chk("t6_rst_pressed", 32'(pressed), 32'h0);
    chk("t6_rst_outs", 32'({press_evt, rx_byte, rx_valid, frame_err}), 32'h0);
    m_pressed = 8'h00;
    m_ext = 1'b0;
    m_brk = 1'b0;
    rst = 1'b0;
    wait_clk(TO + 300);
    send_frame(8'h4D, 1'b0);
    chk("t6_p", 32'(pressed), 32'h80);
    send_frame(8'h1D, 1'b0);
    chk("t6_w_again", 32'(pressed), 32'h81);
    chk("model_pressed", 32'(pressed), 32'(m_pressed));

    wait_clk(20);
    chk("rx_queue_drained",  32'(exp_rx.size()),  32'h0);
    chk("evt_queue_drained", 32'(exp_evt.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
